// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-and-add multiply-accumulate, result_o = factor_a_i * factor_b_i + addend_i
// Ports:
//    clk_i       clock, all state changes on posedge
//    reset_i     synchronous active-high reset, aborts any operation
//    factor_a_i  multiplicand (WIDTH_A), sampled on the accepting edge
//    factor_b_i  multiplier (WIDTH_B), sampled on the accepting edge
//    addend_i    accumulate term (WIDTH_B), sampled on the accepting edge
//    start_i     request, honoured only in IDLE
//    busy_o      high while shifting/accumulating
//    finish_o    single-cycle completion pulse
//    result_o    accumulator, valid from finish_o until the next accepted start
module mul_add_seq #(
   parameter int WIDTH_A = 9,
   parameter int WIDTH_B = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [WIDTH_A-1:0]         factor_a_i,
   input  logic [WIDTH_B-1:0]         factor_b_i,
   input  logic [WIDTH_B-1:0]         addend_i,
   input  logic                       start_i,
   output logic                       busy_o,
   output logic                       finish_o,
   output logic [WIDTH_A+WIDTH_B-1:0] result_o
);
   localparam int W = WIDTH_A + WIDTH_B;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FINISH = 2'd2} state_t;
   state_t state, state_nxt;
   logic [W-1:0] acc, a_sh;
   logic [WIDTH_B-1:0] b_sh;
   logic accept;
   assign accept = (state == IDLE) && start_i;
   always_comb begin
      state_nxt = IDLE;
      if (state == IDLE)
         state_nxt = start_i ? ((factor_b_i == '0) ? FINISH : BUSY) : IDLE;
      else if (state == BUSY)
         // finish once the multiplier bits still to be consumed are all zero
         state_nxt = (b_sh[WIDTH_B-1:1] == '0) ? FINISH : BUSY;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         acc   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            acc  <= {{WIDTH_A{1'b0}}, addend_i};
            a_sh <= {{WIDTH_B{1'b0}}, factor_a_i};
            b_sh <= factor_b_i;
         end else if (state == BUSY) begin
            acc  <= acc + (b_sh[0] ? a_sh : '0);
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
         end
      end
   end
   assign busy_o   = (state == BUSY);
   assign finish_o = (state == FINISH);
   assign result_o = acc;
endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: directed table plus corner sequences and random scoreboard for mul_add_seq
module tb_mul_add_seq;
   logic        clk_i = 0;
   logic        reset_i = 0;
   logic [8:0]  factor_a_i = 0;
   logic [7:0]  factor_b_i = 0;
   logic [7:0]  addend_i = 0;
   logic        start_i = 0;
   logic        busy_o, finish_o;
   logic [16:0] result_o;
   int errors = 0;
   int checks = 0;
   bit overlap = 0;
   mul_add_seq dut (
      .clk_i(clk_i), .reset_i(reset_i), .factor_a_i(factor_a_i), .factor_b_i(factor_b_i),
      .addend_i(addend_i), .start_i(start_i), .busy_o(busy_o), .finish_o(finish_o), .result_o(result_o)
   );
   always #5 clk_i = ~clk_i;
   typedef struct {
      logic [8:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [16:0] res;
      int          nbusy;
   } vec_t;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic accept_op(input logic [8:0] a, input logic [7:0] b, input logic [7:0] c);
      @(negedge clk_i);
      factor_a_i = a;
      factor_b_i = b;
      addend_i   = c;
      start_i    = 1;
      @(posedge clk_i);
      #1;
      start_i    = 0;
      factor_a_i = 9'($urandom);
      factor_b_i = 8'($urandom);
      addend_i   = 8'($urandom);
   endtask
   task automatic wait_done(output int nb, output logic [16:0] res, output bit fin);
      nb = 0;
      res = 0;
      fin = 0;
      overlap = 0;
      for (int i = 0; i < 20 && !fin; i++) begin
         if (busy_o && finish_o) overlap = 1;
         if (finish_o) begin
            fin = 1;
            res = result_o;
         end else begin
            if (busy_o) nb++;
            @(posedge clk_i);
            #1;
         end
      end
      @(posedge clk_i);
      #1;
   endtask
   function automatic int msb_count(input logic [7:0] b);
      int n = 0;
      for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
      return n;
   endfunction
   initial begin
      vec_t vecs[8];
      int nb, fcnt;
      logic [16:0] res;
      bit fin;
      vecs[0] = '{9'd9,   8'd7,   8'd3,   17'd66,     3};
      vecs[1] = '{9'd100, 8'd0,   8'd5,   17'd5,      0};
      vecs[2] = '{9'd511, 8'd255, 8'd255, 17'd130560, 8};
      vecs[3] = '{9'd0,   8'd128, 8'd0,   17'd0,      8};
      vecs[4] = '{9'd3,   8'd6,   8'd1,   17'd19,     3};
      vecs[5] = '{9'd2,   8'd1,   8'd0,   17'd2,      1};
      vecs[6] = '{9'd511, 8'd1,   8'd0,   17'd511,    1};
      vecs[7] = '{9'd0,   8'd0,   8'd255, 17'd255,    0};
      // reset held with start high: nothing may start
      @(negedge clk_i);
      reset_i = 1;
      start_i = 1;
      factor_a_i = 9'd5;
      factor_b_i = 8'd5;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk_i);
         #1;
         chk("reset_busy", busy_o, 0);
         chk("reset_finish", finish_o, 0);
         chk("reset_result", result_o, 0);
      end
      start_i = 0;
      reset_i = 0;
      @(posedge clk_i);
      #1;
      chk("post_reset_busy", busy_o, 0);
      for (int v = 0; v < 8; v++) begin
         accept_op(vecs[v].a, vecs[v].b, vecs[v].c);
         wait_done(nb, res, fin);
         chk($sformatf("vec%0d_finish", v), fin, 1);
         chk($sformatf("vec%0d_result", v), res, vecs[v].res);
         chk($sformatf("vec%0d_nbusy", v), nb, vecs[v].nbusy);
         chk($sformatf("vec%0d_overlap", v), overlap, 0);
         chk($sformatf("vec%0d_idle_busy", v), busy_o, 0);
         chk($sformatf("vec%0d_idle_finish", v), finish_o, 0);
         chk($sformatf("vec%0d_hold", v), result_o, vecs[v].res);
      end
      // start pulse with other operands during BUSY is ignored
      accept_op(9'd3, 8'd6, 8'd1);
      chk("ign_busy1", busy_o, 1);
      start_i = 1;
      factor_a_i = 9'd1;
      factor_b_i = 8'd1;
      addend_i = 8'd0;
      @(posedge clk_i);
      #1;
      start_i = 0;
      wait_done(nb, res, fin);
      chk("ign_finish", fin, 1);
      chk("ign_result", res, 19);
      chk("ign_nbusy_rest", nb, 2);
      // reset in the second BUSY cycle aborts without a finish pulse
      accept_op(9'd3, 8'd6, 8'd1);
      @(posedge clk_i);
      #1;
      chk("abort_busy2", busy_o, 1);
      reset_i = 1;
      @(posedge clk_i);
      #1;
      reset_i = 0;
      chk("abort_busy", busy_o, 0);
      chk("abort_finish", finish_o, 0);
      chk("abort_result", result_o, 0);
      fcnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (finish_o || busy_o) fcnt++;
         @(posedge clk_i);
         #1;
      end
      chk("abort_quiet", fcnt, 0);
      // start held continuously: BUSY, FINISH, IDLE repeating
      @(negedge clk_i);
      factor_a_i = 9'd2;
      factor_b_i = 8'd1;
      addend_i = 8'd0;
      start_i = 1;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("cont%0d_busy", k), busy_o, (k % 3) == 0);
         chk($sformatf("cont%0d_finish", k), finish_o, (k % 3) == 1);
         if (k % 3 == 1) chk($sformatf("cont%0d_result", k), result_o, 2);
         @(posedge clk_i);
         #1;
      end
      start_i = 0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("cont_drain_idle", busy_o | finish_o, 0);
      // random scoreboard
      for (int r = 0; r < 1000; r++) begin
         logic [8:0] a;
         logic [7:0] b, c;
         int exp_v;
         a = 9'($urandom);
         b = 8'($urandom);
         c = 8'($urandom);
         if (r % 10 == 0) b = 8'd0;
         exp_v = int'(a) * int'(b) + int'(c);
         accept_op(a, b, c);
         wait_done(nb, res, fin);
         checks++;
         if (!fin || res !== 17'(exp_v) || nb != msb_count(b) || overlap) begin
            errors++;
            $display("FAIL rand%0d a=%0d b=%0d c=%0d: got res=%0d nb=%0d fin=%0d ovl=%0d expected res=%0d nb=%0d",
                     r, a, b, c, res, nb, fin, overlap, exp_v, msb_count(b));
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
